// File: rtl/i2s_pkg.sv
// Shared types and default sizing for the I2S stereo receiver.
// Optional frame counter on the top level is enabled by defining I2S_RX_FRAME_CNT_EN.
package i2s_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  localparam int DEFAULT_DATA_W   = 24;
  localparam int DEFAULT_SLOT_W   = 32;
  localparam int DEFAULT_BCLK_DIV = 8;

  // Number of BCLK periods between the LRCLK edge and the sample MSB.
  function automatic logic data_delay(fmt_e fmt);
    return (fmt == FMT_I2S);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK/LRCLK generator: owns the divider and slot bit counters and
// provides the capture strobe and current bit position to the receiver.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = DEFAULT_SLOT_W,
  parameter int BCLK_DIV = DEFAULT_BCLK_DIV,
  localparam int DIV_CW  = $clog2(BCLK_DIV),
  localparam int BIT_CW  = $clog2(SLOT_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              rise_o,
  output logic              frame_start_o,
  output logic [BIT_CW-1:0] bit_idx_o,
  output chan_e             chan_o
);

  localparam logic [DIV_CW-1:0] DIV_HALF = DIV_CW'(BCLK_DIV / 2);
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(BCLK_DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(SLOT_W - 1);

  logic [DIV_CW-1:0] div_cnt_reg;
  logic [BIT_CW-1:0] bit_cnt_reg;
  logic [DIV_CW-1:0] div_next;
  logic              fall;

  assign rise_o        = enable_i && (div_cnt_reg == DIV_HALF);
  assign fall          = enable_i && (div_cnt_reg == DIV_LAST);
  assign div_next      = fall ? '0 : div_cnt_reg + 1'b1;
  assign frame_start_o = enable_i && (div_cnt_reg == '0) && (bit_cnt_reg == '0) && !lrclk_o;
  assign bit_idx_o     = bit_cnt_reg;
  assign chan_o        = chan_e'(lrclk_o);

  // bclk_o is registered from the next divider value so it tracks div_cnt exactly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      bclk_o      <= 1'b0;
      lrclk_o     <= 1'b0;
    end else if (!enable_i) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      bclk_o      <= 1'b0;
      lrclk_o     <= 1'b0;
    end else begin
      div_cnt_reg <= div_next;
      bclk_o      <= (div_next >= DIV_HALF);
      if (fall) begin
        if (bit_cnt_reg == BIT_LAST) begin
          bit_cnt_reg <= '0;
          lrclk_o     <= ~lrclk_o;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_rx_stereo.sv
// I2S / left-justified bus-master stereo receiver with valid/ready frame output.
// Define I2S_RX_FRAME_CNT_EN to add the 16-bit completed-frame counter output.
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int SLOT_W   = DEFAULT_SLOT_W,
  parameter int BCLK_DIV = DEFAULT_BCLK_DIV
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              format_i,
  input  logic              sd_i,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overrun_o
`ifdef I2S_RX_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt_o
`endif
);

  localparam int BIT_CW = $clog2(SLOT_W);

  logic              rise;
  logic              frame_start;
  logic [BIT_CW-1:0] bit_idx;
  chan_e             chan;
  fmt_e              fmt_reg;
  logic [DATA_W-1:0] left_sh_reg;
  logic [DATA_W-1:0] right_sh_reg;
  logic [BIT_CW:0]   rel_bit;
  logic              in_window;
  logic              frame_done;

  i2s_clk_gen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .bclk_o        (bclk_o),
    .lrclk_o       (lrclk_o),
    .rise_o        (rise),
    .frame_start_o (frame_start),
    .bit_idx_o     (bit_idx),
    .chan_o        (chan)
  );

  // Position within the data word; wraps to a large value before the I2S MSB slot bit.
  assign rel_bit    = {1'b0, bit_idx} - {{BIT_CW{1'b0}}, data_delay(fmt_reg)};
  assign in_window  = rel_bit < (BIT_CW + 1)'(DATA_W);
  assign frame_done = rise && (chan == CH_RIGHT) && (rel_bit == (BIT_CW + 1)'(DATA_W - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fmt_reg      <= FMT_I2S;
      left_sh_reg  <= '0;
      right_sh_reg <= '0;
      left_o       <= '0;
      right_o      <= '0;
      valid_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (frame_start) begin
        fmt_reg <= fmt_e'(format_i);
      end
      if (rise && in_window) begin
        if (chan == CH_LEFT) begin
          left_sh_reg <= {left_sh_reg[DATA_W-2:0], sd_i};
        end else begin
          right_sh_reg <= {right_sh_reg[DATA_W-2:0], sd_i};
        end
      end
      // A completion always wins over an accept in the same cycle, keeping valid_o high.
      if (frame_done) begin
        left_o    <= left_sh_reg;
        right_o   <= {right_sh_reg[DATA_W-2:0], sd_i};
        valid_o   <= 1'b1;
        overrun_o <= valid_o && !ready_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_reg <= '0;
    end else if (frame_done) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Self-checking bench for i2s_rx_stereo: a default instance and a 16/16/4 instance
// share control inputs; a cycle-index codec model drives SD and predicts outputs.
module tb_i2s_rx_stereo;

  localparam int NI = 2;

  function automatic int dw(int i);   return (i == 0) ? 24 : 16; endfunction
  function automatic int sw(int i);   return (i == 0) ? 32 : 16; endfunction
  function automatic int dv(int i);   return (i == 0) ? 8  : 4;  endfunction
  function automatic int flen(int i); return 2 * sw(i) * dv(i);  endfunction
  function automatic logic [31:0] mask(int i);
    return (32'd1 << dw(i)) - 32'd1;
  endfunction

  logic clk_i;
  logic rst_i, enable_i, format_i, ready_i;
  logic sd0, sd1;
  logic bclk0, lrclk0, valid0, ovr0;
  logic bclk1, lrclk1, valid1, ovr1;
  logic [23:0] left0, right0;
  logic [15:0] left1, right1;
`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] fcnt0, fcnt1;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  i2s_rx_stereo u_dut (
    .clk_i (clk_i), .rst_i (rst_i), .enable_i (enable_i), .format_i (format_i),
    .sd_i (sd0), .bclk_o (bclk0), .lrclk_o (lrclk0), .left_o (left0), .right_o (right0),
    .valid_o (valid0), .ready_i (ready_i), .overrun_o (ovr0)
`ifdef I2S_RX_FRAME_CNT_EN
    , .frame_cnt_o (fcnt0)
`endif
  );

  i2s_rx_stereo #(.DATA_W (16), .SLOT_W (16), .BCLK_DIV (4)) u_dut16 (
    .clk_i (clk_i), .rst_i (rst_i), .enable_i (enable_i), .format_i (format_i),
    .sd_i (sd1), .bclk_o (bclk1), .lrclk_o (lrclk1), .left_o (left1), .right_o (right1),
    .valid_o (valid1), .ready_i (ready_i), .overrun_o (ovr1)
`ifdef I2S_RX_FRAME_CNT_EN
    , .frame_cnt_o (fcnt1)
`endif
  );

  typedef struct packed { logic [31:0] l; logic [31:0] r; } frame_t;
  typedef struct packed {
    logic        fmt;
    logic [31:0] l, r, exp_l, exp_r;
  } vec_t;

  // Reference model state, per instance
  int unsigned t      [NI];
  logic        m_fmt  [NI];
  logic [31:0] cur_l  [NI], cur_r [NI];
  logic [31:0] m_left [NI], m_right [NI];
  logic        m_valid[NI], m_ovr [NI];
  logic [15:0] m_cnt  [NI];
  frame_t      q0[$], q1[$];

  int n_checks, n_errors;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      t[i] = 0; m_fmt[i] = 1'b0; cur_l[i] = '0; cur_r[i] = '0;
      m_left[i] = '0; m_right[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0; m_cnt[i] = '0;
    end
  endfunction

  // Codec: slot bit k carries sample bit (DATA_W-1-(k-delay)); other slot bits are noise.
  function automatic logic sd_model(int i);
    int unsigned pos = (t[i] / dv(i)) % sw(i);
    int unsigned ch  = (t[i] / (dv(i) * sw(i))) % 2;
    int          k   = int'(pos) - (m_fmt[i] ? 0 : 1);
    logic [31:0] w   = (ch == 1) ? cur_r[i] : cur_l[i];
    if (k >= 0 && k < dw(i)) return w[dw(i) - 1 - k];
    return 1'($urandom);
  endfunction

  // One clock: inputs set by the caller apply to the current cycle; outputs checked at negedge.
  task automatic tick();
    frame_t      f;
    logic        done;
    int          last;
    logic [31:0] ob_l [NI], ob_r [NI];
    logic        ob_b [NI], ob_lr [NI], ob_v [NI], ob_o [NI];
    for (int i = 0; i < NI; i++) begin
      if (enable_i && (t[i] % flen(i)) == 0) begin
        m_fmt[i] = format_i;
        if (i == 0 && q0.size() > 0) f = q0.pop_front();
        else if (i == 1 && q1.size() > 0) f = q1.pop_front();
        else begin f.l = $urandom; f.r = $urandom; end
        cur_l[i] = f.l & mask(i);
        cur_r[i] = f.r & mask(i);
      end
    end
    sd0 = enable_i ? sd_model(0) : 1'($urandom);
    sd1 = enable_i ? sd_model(1) : 1'($urandom);
    @(posedge clk_i);
    for (int i = 0; i < NI; i++) begin
      last = dw(i) - 1 + (m_fmt[i] ? 0 : 1);
      done = enable_i && (t[i] % dv(i)) == dv(i) / 2 &&
             ((t[i] / (dv(i) * sw(i))) % 2) == 1 && int'((t[i] / dv(i)) % sw(i)) == last;
      if (done) begin
        m_ovr[i]   = m_valid[i] && !ready_i;
        m_valid[i] = 1'b1;
        m_left[i]  = cur_l[i];
        m_right[i] = cur_r[i];
        m_cnt[i]   = m_cnt[i] + 16'd1;
        $display("dut%0d frame %0d: fmt=%0d left=%h right=%h overrun=%0d",
                 i, m_cnt[i], m_fmt[i], cur_l[i], cur_r[i], m_ovr[i]);
      end else begin
        m_ovr[i] = 1'b0;
        if (m_valid[i] && ready_i) m_valid[i] = 1'b0;
      end
      t[i] = enable_i ? t[i] + 1 : 0;
    end
    @(negedge clk_i);
    ob_l[0] = 32'(left0); ob_r[0] = 32'(right0); ob_b[0] = bclk0; ob_lr[0] = lrclk0;
    ob_v[0] = valid0; ob_o[0] = ovr0;
    ob_l[1] = 32'(left1); ob_r[1] = 32'(right1); ob_b[1] = bclk1; ob_lr[1] = lrclk1;
    ob_v[1] = valid1; ob_o[1] = ovr1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("bclk%0d", i), 32'(ob_b[i]), 32'((t[i] % dv(i)) >= dv(i) / 2));
      chk($sformatf("lrclk%0d", i), 32'(ob_lr[i]), 32'((t[i] / (dv(i) * sw(i))) % 2));
      chk($sformatf("valid%0d", i), 32'(ob_v[i]), 32'(m_valid[i]));
      chk($sformatf("overrun%0d", i), 32'(ob_o[i]), 32'(m_ovr[i]));
      chk($sformatf("left%0d", i), ob_l[i], m_left[i]);
      chk($sformatf("right%0d", i), ob_r[i], m_right[i]);
    end
`ifdef I2S_RX_FRAME_CNT_EN
    chk("frame_cnt0", 32'(fcnt0), 32'(m_cnt[0]));
    chk("frame_cnt1", 32'(fcnt1), 32'(m_cnt[1]));
`endif
  endtask

  initial begin
    vec_t vecs [4];
    int   n_valid, n_ovr;
    vecs[0] = '{fmt: 1'b0, l: 32'h20F3FF, r: 32'hA5A5A5, exp_l: 32'h20F3FF, exp_r: 32'hA5A5A5};
    vecs[1] = '{fmt: 1'b1, l: 32'h800001, r: 32'h7FFFFE, exp_l: 32'h800001, exp_r: 32'h7FFFFE};
    vecs[2] = '{fmt: 1'b0, l: 32'h000000, r: 32'hFFFFFF, exp_l: 32'h000000, exp_r: 32'hFFFFFF};
    vecs[3] = '{fmt: 1'b1, l: 32'hFFFFFF, r: 32'h000001, exp_l: 32'hFFFFFF, exp_r: 32'h000001};
    n_checks = 0; n_errors = 0;
    rst_i = 1'b1; enable_i = 1'b0; format_i = 1'b0; ready_i = 1'b1; sd0 = 1'b0; sd1 = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_bclk", 32'(bclk0), 0);
    chk("rst_lrclk", 32'(lrclk0), 0);
    chk("rst_left", 32'(left0), 0);
    chk("rst_right", 32'(right0), 0);
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_overrun", 32'(ovr0), 0);
    rst_i = 1'b0;
    repeat (100) tick();

    // Table-driven frames, ready held high
    enable_i = 1'b1;
    for (int v = 0; v < 4; v++) begin
      format_i = vecs[v].fmt;
      q0.push_back('{l: vecs[v].l, r: vecs[v].r});
      n_valid = 0;
      repeat (flen(0)) begin
        tick();
        if (valid0) n_valid++;
      end
      chk($sformatf("tbl%0d_left", v), 32'(left0), vecs[v].exp_l);
      chk($sformatf("tbl%0d_right", v), 32'(right0), vecs[v].exp_r);
      chk($sformatf("tbl%0d_valid_cycles", v), n_valid, 1);
    end

    // Format change mid-frame takes effect only at the next frame
    format_i = 1'b0;
    q0.push_back('{l: 32'h123456, r: 32'h654321});
    repeat (flen(0) / 2) tick();
    format_i = 1'b1;
    q0.push_back('{l: 32'h800001, r: 32'h7FFFFE});
    repeat (flen(0) / 2) tick();
    chk("fmtchg_old_left", 32'(left0), 32'h123456);
    chk("fmtchg_old_right", 32'(right0), 32'h654321);
    repeat (flen(0)) tick();
    chk("fmtchg_lj_left", 32'(left0), 32'h800001);
    chk("fmtchg_lj_right", 32'(right0), 32'h7FFFFE);

    // Narrow instance, left-justified
    q1.push_back('{l: 32'hBEEF, r: 32'h1234});
    repeat (flen(1)) tick();
    chk("w16_left", 32'(left1), 32'hBEEF);
    chk("w16_right", 32'(right1), 32'h1234);
    repeat (flen(0) - flen(1)) tick();

    // Backpressure across two frames
    format_i = 1'b0;
    ready_i  = 1'b0;
    q0.push_back('{l: 32'h111111, r: 32'h222222});
    q0.push_back('{l: 32'h333333, r: 32'h444444});
    n_ovr = 0;
    repeat (2 * flen(0)) begin
      tick();
      if (ovr0) n_ovr++;
    end
    chk("bp_overrun_pulses", n_ovr, 1);
    chk("bp_left", 32'(left0), 32'h333333);
    chk("bp_right", 32'(right0), 32'h444444);
    chk("bp_valid_held", 32'(valid0), 1);
    ready_i = 1'b1;
    tick();
    chk("bp_valid_clear", 32'(valid0), 0);

    // Enable drop at left slot bit 10 while BCLK is high
    repeat (10 * dv(0) + 6 - 1) tick();
    enable_i = 1'b0;
    tick();
    chk("drop_bclk", 32'(bclk0), 0);
    chk("drop_lrclk", 32'(lrclk0), 0);
    n_valid = 0;
    repeat (50) begin
      tick();
      if (valid0) n_valid++;
    end
    chk("drop_no_valid", n_valid, 0);
    enable_i = 1'b1;
    q0.push_back('{l: 32'hABCDEF, r: 32'h13579B});
    n_valid = 0;
    repeat (flen(0)) begin
      tick();
      if (valid0) n_valid++;
    end
    chk("reen_valid_cycles", n_valid, 1);
    chk("reen_left", 32'(left0), 32'hABCDEF);
    chk("reen_right", 32'(right0), 32'h13579B);

    // Randomized frames, format and backpressure
    for (int fr = 0; fr < 6; fr++) begin
      format_i = 1'($urandom);
      repeat (flen(0)) begin
        ready_i = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    // Asynchronous reset clears outputs without a clock edge
    rst_i = 1'b1;
    #1;
    chk("arst_left", 32'(left0), 0);
    chk("arst_right", 32'(right0), 0);
    chk("arst_valid", 32'(valid0), 0);
    chk("arst_lrclk", 32'(lrclk0), 0);
`ifdef I2S_RX_FRAME_CNT_EN
    chk("arst_frame_cnt", 32'(fcnt0), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
